// File: rtl/smaesh_svrs_share_loader.sv
// Share loader for the masked AES core: assembles 8*d 32-bit words into one
// shared plaintext/key transaction and holds it sticky until the core accepts.
module smaesh_svrs_share_loader #(
    parameter int d     = 2,
    parameter int CNT_W = $clog2(8*d)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        s_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               flush,
    output logic [128*d-1:0]   m_plain,
    output logic [128*d-1:0]   m_key,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [CNT_W-1:0]   fill_level
);

    typedef enum logic {FILL, HOLD} state_e;

    localparam int               HALF_WORDS = 4*d;
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(8*d - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [128*d-1:0]   plain_q;
    logic [128*d-1:0]   key_q;
    logic               wr_en;

    // A flushed cycle never stores its word, even though s_ready is high.
    assign wr_en = (state_q == FILL) && s_valid && !flush;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a variable
        // unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            FILL: begin
                if (flush) begin
                    cnt_d = '0;
                end else if (s_valid) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (m_ready) state_d = FILL;
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
            end
        endcase
    end

    // Data words: one write-enabled 32-bit slot per word index.
    for (genvar w = 0; w < HALF_WORDS; w++) begin : g_words
        // NOTE: the data registers carry no reset; they are only observed
        // while m_valid=1, by which point every slot has been written.
        always_ff @(posedge clk) begin
            if (wr_en && cnt_q == CNT_W'(w))
                plain_q[32*w +: 32] <= s_data;
            if (wr_en && cnt_q == CNT_W'(w + HALF_WORDS))
                key_q[32*w +: 32] <= s_data;
        end
    end

    // Outputs, decoded from registers only
    always_comb begin
        s_ready    = (state_q == FILL);
        m_valid    = (state_q == HOLD);
        fill_level = (state_q == FILL) ? cnt_q : '0;
    end

    assign m_plain = plain_q;
    assign m_key   = key_q;

endmodule

// File: tb/tb_smaesh_svrs_share_loader.sv
// Directed self-checking bench for the share loader (d=2, 16 words/transaction).
module tb_smaesh_svrs_share_loader;

    localparam int D     = 2;
    localparam int CNT_W = $clog2(8*D);

    logic               clk;
    logic               rst;
    logic [31:0]        s_data;
    logic               s_valid;
    logic               s_ready;
    logic               flush;
    logic [128*D-1:0]   m_plain;
    logic [128*D-1:0]   m_key;
    logic               m_valid;
    logic               m_ready;
    logic [CNT_W-1:0]   fill_level;

    int total = 0;
    int bad   = 0;

    smaesh_svrs_share_loader #(.d(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .flush      (flush),
        .m_plain    (m_plain),
        .m_key      (m_key),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fill_level (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected half-transaction: word w of the half holds base+off+w.
    function automatic logic [128*D-1:0] exp_vec(input logic [31:0] base, input int off);
        logic [128*D-1:0] v;
        for (int w = 0; w < 4*D; w++) v[32*w +: 32] = base + 32'(off + w);
        return v;
    endfunction

    task automatic send_words(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            s_valid = 1'b1;
            s_data  = base + 32'(k);
            step();
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        total++; if (fill_level !== '0) begin bad++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 16; k++) begin
            s_valid = 1'b1;
            s_data  = 32'(k);
            step();
            if (k < 15) begin
                total++;
                if (fill_level !== CNT_W'(k + 1) || m_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL fill_progress k=%0d got fill=%0d m_valid=%b exp fill=%0d m_valid=0",
                             k, fill_level, m_valid, k + 1);
                end
            end
        end
        s_valid = 1'b0;
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL fill_s_ready got=%b exp=0", s_ready); end
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL fill_m_valid got=%b exp=1", m_valid); end
        total++; if (m_plain[31:0] !== 32'h0) begin bad++; $display("FAIL fill_plain_w0 got=%h exp=0", m_plain[31:0]); end
        total++; if (m_key[255:224] !== 32'h0F) begin bad++; $display("FAIL fill_key_w7 got=%h exp=0f", m_key[255:224]); end
        total++; if (m_plain !== exp_vec(32'h0, 0)) begin bad++; $display("FAIL fill_plain got=%h exp=%h", m_plain, exp_vec(32'h0, 0)); end
        total++; if (m_key !== exp_vec(32'h0, 8)) begin bad++; $display("FAIL fill_key got=%h exp=%h", m_key, exp_vec(32'h0, 8)); end
    endtask

    task automatic test_hold_stall();
        m_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            s_valid = 1'b1;
            s_data  = 32'hA000_0000 + 32'(k);
            step();
            total++;
            if (m_valid !== 1'b1 || s_ready !== 1'b0 || fill_level !== '0 ||
                m_plain !== exp_vec(32'h0, 0) || m_key !== exp_vec(32'h0, 8)) begin
                bad++;
                $display("FAIL hold_stall k=%0d got m_valid=%b s_ready=%b fill=%0d plain=%h key=%h exp 1 0 0 and data frozen",
                         k, m_valid, s_ready, fill_level, m_plain, m_key);
            end
        end
        m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        m_ready = 1'b0;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL hold_release_m_valid got=%b exp=0", m_valid); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL hold_release_s_ready got=%b exp=1", s_ready); end
        total++; if (fill_level !== '0) begin bad++; $display("FAIL hold_no_consume got=%0d exp=0", fill_level); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int first_t;
        int second_t;
        pulses   = 0;
        first_t  = -1;
        second_t = -1;
        m_ready  = 1'b1;
        for (int t = 0; t < 34; t++) begin
            s_valid = 1'b1;
            if (t < 16)       s_data = 32'h100 + 32'(t);
            else if (t == 16) s_data = 32'hDEAD_BEEF;
            else              s_data = 32'h200 + 32'(t - 17);
            step();
            if (m_valid === 1'b1) begin
                pulses++;
                if (first_t < 0) first_t = t; else second_t = t;
                total++;
                if (pulses == 1 && (m_plain !== exp_vec(32'h100, 0) || m_key !== exp_vec(32'h100, 8))) begin
                    bad++;
                    $display("FAIL b2b_data1 got plain=%h key=%h exp plain=%h key=%h",
                             m_plain, m_key, exp_vec(32'h100, 0), exp_vec(32'h100, 8));
                end else if (pulses == 2 && (m_plain !== exp_vec(32'h200, 0) || m_key !== exp_vec(32'h200, 8))) begin
                    bad++;
                    $display("FAIL b2b_data2 got plain=%h key=%h exp plain=%h key=%h",
                             m_plain, m_key, exp_vec(32'h200, 0), exp_vec(32'h200, 8));
                end
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        total++; if (pulses !== 2) begin bad++; $display("FAIL b2b_pulse_count got=%0d exp=2", pulses); end
        total++; if (first_t !== 15) begin bad++; $display("FAIL b2b_first_pulse got=%0d exp=15", first_t); end
        total++; if (second_t - first_t !== 17) begin bad++; $display("FAIL b2b_spacing got=%0d exp=17", second_t - first_t); end
    endtask

    task automatic test_flush();
        send_words(32'h300, 5);
        total++; if (fill_level !== CNT_W'(5)) begin bad++; $display("FAIL flush_pre_fill got=%0d exp=5", fill_level); end
        flush   = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'hBAD0_BAD0;
        step();
        flush   = 1'b0;
        s_valid = 1'b0;
        total++; if (fill_level !== '0) begin bad++; $display("FAIL flush_fill got=%0d exp=0", fill_level); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL flush_s_ready got=%b exp=1", s_ready); end
        send_words(32'h400, 15);
        total++; if (m_valid !== 1'b0 || fill_level !== CNT_W'(15)) begin
            bad++; $display("FAIL flush_partial got m_valid=%b fill=%0d exp m_valid=0 fill=15", m_valid, fill_level);
        end
        send_words(32'h40F, 1);
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL flush_txn_valid got=%b exp=1", m_valid); end
        total++; if (m_plain !== exp_vec(32'h400, 0) || m_key !== exp_vec(32'h400, 8)) begin
            bad++; $display("FAIL flush_txn_data got plain=%h key=%h exp plain=%h key=%h",
                            m_plain, m_key, exp_vec(32'h400, 0), exp_vec(32'h400, 8));
        end
    endtask

    task automatic test_flush_in_hold();
        for (int k = 0; k < 3; k++) begin
            flush   = 1'b1;
            s_valid = 1'b1;
            s_data  = 32'h5000 + 32'(k);
            step();
            total++;
            if (m_valid !== 1'b1 || m_plain !== exp_vec(32'h400, 0) || m_key !== exp_vec(32'h400, 8)) begin
                bad++;
                $display("FAIL flush_hold k=%0d got m_valid=%b plain=%h key=%h exp m_valid=1 data frozen",
                         k, m_valid, m_plain, m_key);
            end
        end
        flush   = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        // Still in HOLD from the previous test.
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (m_valid !== 1'b0 || s_ready !== 1'b1 || fill_level !== '0) begin
            bad++; $display("FAIL rst_hold got m_valid=%b s_ready=%b fill=%0d exp 0 1 0", m_valid, s_ready, fill_level);
        end
        send_words(32'h600, 7);
        total++; if (fill_level !== CNT_W'(7)) begin bad++; $display("FAIL rst_pre_fill got=%0d exp=7", fill_level); end
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'hFFFF_0000;
        step();
        rst     = 1'b0;
        s_valid = 1'b0;
        total++; if (m_valid !== 1'b0 || s_ready !== 1'b1 || fill_level !== '0) begin
            bad++; $display("FAIL rst_fill got m_valid=%b s_ready=%b fill=%0d exp 0 1 0", m_valid, s_ready, fill_level);
        end
        send_words(32'h700, 16);
        total++; if (m_valid !== 1'b1 || m_plain !== exp_vec(32'h700, 0) || m_key !== exp_vec(32'h700, 8)) begin
            bad++; $display("FAIL rst_new_txn got m_valid=%b plain=%h key=%h exp m_valid=1 plain=%h key=%h",
                            m_valid, m_plain, m_key, exp_vec(32'h700, 0), exp_vec(32'h700, 8));
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        total++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            bad++; $display("FAIL rst_final_handshake got m_valid=%b s_ready=%b exp 0 1", m_valid, s_ready);
        end
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        flush   = 1'b0;
        m_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        test_reset();
        test_fill();
        test_hold_stall();
        test_back_to_back();
        test_flush();
        test_flush_in_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
